// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and round-robin helpers for rr_arbiter_8.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

    // First set bit of req scanning ptr, ptr+1, ... with modulo-8 wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and rr_arbiter_8 (slave).
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface rr_arbiter_8_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
`ifdef RR_ARB_LOCK_EN
    logic             lock;

    modport master (output req, done, lock, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, done, lock, output gnt, gnt_idx, gnt_valid);
`else
    modport master (output req, done, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_valid);
`endif

endinterface

// File: rtl/onehot_dec_3_8.sv
// Enabled 3-to-8 one-hot decoder; all zeros when disabled.
module onehot_dec_3_8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with grant hold and optional hold timeout.
// Define RR_ARB_LOCK_EN to add a lock input that suppresses the timeout.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter_8_if.slave bus
);

    localparam int unsigned    HOLD_W     = $clog2(MAX_HOLD) + 1;
    localparam int unsigned    HOLD_LIM   = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM_C = HOLD_W'(HOLD_LIM);

    logic              state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              lock_hold;
    logic              timeout;
    logic              release_own;

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // >= rather than == so a lock held past the limit releases as soon as it drops.
    assign timeout     = (MAX_HOLD != 0) && (cnt_q >= HOLD_LIM_C) && !lock_hold;
    assign release_own = bus.done[owner_q] || !bus.req[owner_q] || timeout;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_d = rr_pick(bus.req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cnt_q != '1) cnt_d = cnt_q + HOLD_W'(1);
                if (release_own) begin
                    state_d = ST_IDLE;
                    ptr_d   = rr_next(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt_idx   = owner_q;
    assign bus.gnt_valid = (state_q == ST_GRANT);

    onehot_dec_3_8 u_dec (
        .idx (bus.gnt_idx),
        .en  (bus.gnt_valid),
        .y   (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=4); lock checks run when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter_8;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic [7:0] done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    localparam int NVEC = 27;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    vec_t tbl [NVEC];

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev);
        vectors++;
        if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%0b, want gnt=%h idx=%0d valid=%0b",
                     name, bus.gnt, bus.gnt_idx, bus.gnt_valid, eg, ei, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;
`ifdef RR_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        //              rst   req    done   gnt    idx   valid
        tbl[0]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'hFF, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'hFF, 8'h00, 8'h02, 3'd1, 1'b1};
        tbl[5]  = '{1'b0, 8'hFF, 8'h02, 8'h00, 3'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'hFF, 8'h00, 8'h04, 3'd2, 1'b1};
        tbl[7]  = '{1'b0, 8'hFF, 8'h04, 8'h00, 3'd2, 1'b0};
        tbl[8]  = '{1'b0, 8'hFF, 8'h00, 8'h08, 3'd3, 1'b1};
        tbl[9]  = '{1'b0, 8'hFF, 8'h08, 8'h00, 3'd3, 1'b0};
        tbl[10] = '{1'b0, 8'hFF, 8'h00, 8'h10, 3'd4, 1'b1};
        tbl[11] = '{1'b0, 8'hFF, 8'h10, 8'h00, 3'd4, 1'b0};
        tbl[12] = '{1'b0, 8'hFF, 8'h00, 8'h20, 3'd5, 1'b1};
        tbl[13] = '{1'b0, 8'hFF, 8'h20, 8'h00, 3'd5, 1'b0};
        // ptr=6: scan 6,7 wraps to 0, then 2
        tbl[14] = '{1'b0, 8'h05, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[15] = '{1'b0, 8'h05, 8'h01, 8'h00, 3'd0, 1'b0};
        tbl[16] = '{1'b0, 8'h05, 8'h00, 8'h04, 3'd2, 1'b1};
        // non-owner done ignored, then mid-grant reset
        tbl[17] = '{1'b0, 8'h05, 8'h10, 8'h04, 3'd2, 1'b1};
        tbl[18] = '{1'b0, 8'h05, 8'h00, 8'h04, 3'd2, 1'b1};
        tbl[19] = '{1'b1, 8'h05, 8'h00, 8'h00, 3'd0, 1'b0};
        // ptr back at 0 picks 1 (ptr=3 would pick 4)
        tbl[20] = '{1'b0, 8'h12, 8'h00, 8'h02, 3'd1, 1'b1};
        tbl[21] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0};
        tbl[22] = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b0};
        tbl[23] = '{1'b0, 8'h80, 8'h00, 8'h80, 3'd7, 1'b1};
        tbl[24] = '{1'b0, 8'h81, 8'h80, 8'h00, 3'd7, 1'b0};
        tbl[25] = '{1'b0, 8'h81, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[26] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            rst      = tbl[i].rst;
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            step();
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid);
        end

        // Timeout: four grant cycles, one bubble, then re-grant to the same requester.
        bus.req  = 8'h08;
        bus.done = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("timeout_hold%0d", i), 8'h08, 3'd3, 1'b1);
        end
        step();
        check("timeout_bubble", 8'h00, 3'd3, 1'b0);
        step();
        check("timeout_regrant", 8'h08, 3'd3, 1'b1);
        bus.req = 8'h00;
        step();
        check("timeout_drop", 8'h00, 3'd3, 1'b0);

`ifdef RR_ARB_LOCK_EN
        bus.lock = 1'b1;
        bus.req  = 8'h08;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("lock_hold%0d", i), 8'h08, 3'd3, 1'b1);
        end
        bus.lock = 1'b0;
        step();
        check("lock_release", 8'h00, 3'd3, 1'b0);
        bus.req = 8'h00;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
